// File: rtl/axis_word_burst.sv
// rtl/axis_word_burst.sv - trigger-started fixed-word AXI-Stream burst generator
// Optional `AXIS_WORD_BURST_RAMP_EN: tdata increments by one after each accepted beat.
module axis_word_burst #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int CNTR_WIDTH       = 16
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic [AXIS_TDATA_WIDTH-1:0] data,
    input  logic [CNTR_WIDTH-1:0]       cfg_len,
    input  logic                        trigger,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        m_axis_tlast,
    output logic                        busy,
    output logic                        done
);

    typedef enum logic [1:0] {IDLE, SEND, FIN} state_t;

    state_t                      state_q;
    logic                        trig_q;
    logic                        armed_q;
    logic [CNTR_WIDTH-1:0]       len_q;
    logic [CNTR_WIDTH-1:0]       cnt_q;
    logic [CNTR_WIDTH-1:0]       cnt_d;
    logic [AXIS_TDATA_WIDTH-1:0] tdata_q;
    logic                        tvalid_q;
    logic                        tlast_q;
    logic                        busy_q;
    logic                        done_q;
    logic                        trig_rise;
    logic                        accept;

    // armed_q masks the first sampled cycle after reset so a trigger held
    // high through reset is not mistaken for a fresh rising edge.
    assign trig_rise = trigger & ~trig_q & armed_q;
    assign accept    = tvalid_q & m_axis_tready;
    assign cnt_d     = cnt_q + CNTR_WIDTH'(1);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= IDLE;
            trig_q   <= 1'b0;
            armed_q  <= 1'b0;
            len_q    <= '0;
            cnt_q    <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            trig_q  <= trigger;
            armed_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (trig_rise && (cfg_len != '0)) begin
                        state_q  <= SEND;
                        len_q    <= cfg_len;
                        cnt_q    <= '0;
                        tdata_q  <= data;
                        tvalid_q <= 1'b1;
                        tlast_q  <= (cfg_len == CNTR_WIDTH'(1));
                        busy_q   <= 1'b1;
                    end
                end
                SEND: begin
                    if (accept) begin
                        if (tlast_q) begin
                            state_q  <= FIN;
                            tvalid_q <= 1'b0;
                            tlast_q  <= 1'b0;
                            done_q   <= 1'b1;
                        end else begin
                            cnt_q   <= cnt_d;
                            tlast_q <= (cnt_d == (len_q - CNTR_WIDTH'(1)));
`ifdef AXIS_WORD_BURST_RAMP_EN
                            tdata_q <= tdata_q + AXIS_TDATA_WIDTH'(1);
`else
                            tdata_q <= tdata_q;
`endif
                        end
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_axis_word_burst.sv
// tb/tb_axis_word_burst.sv - scoreboard bench for axis_word_burst
module tb_axis_word_burst;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [31:0] data;
    logic [15:0] cfg_len;
    logic        trigger;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic        busy;
    logic        done;

    axis_word_burst #(.AXIS_TDATA_WIDTH(32), .CNTR_WIDTH(16)) dut (
        .aclk(aclk), .aresetn(aresetn), .data(data), .cfg_len(cfg_len),
        .trigger(trigger), .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .busy(busy), .done(done)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [31:0] d;
        logic        l;
    } beat_t;

    beat_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    beats = 0;
    int    done_cnt = 0;
    int    exp_bursts = 0;
    int    busy_cycles = 0;
    int    ready_mode = 1;
    bit    in_reset = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // tready pattern: 0 random, 1 always high, 2 toggling
    logic tog = 1'b0;
    always @(posedge aclk) begin
        #1;
        tog = ~tog;
        case (ready_mode)
            0:       m_axis_tready = 1'($urandom_range(0, 1));
            2:       m_axis_tready = tog;
            default: m_axis_tready = 1'b1;
        endcase
    end

    // Monitor: pops the scoreboard on every accepted beat, checks stalls and done
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data;
    logic        prev_last;
    logic        done_pend = 1'b0;
    always @(negedge aclk) begin
        if (in_reset) begin
            prev_stall = 1'b0;
            done_pend  = 1'b0;
        end else begin
            beat_t b;
            logic  nxt_pend;
            nxt_pend = 1'b0;
            if (prev_stall) begin
                check("stall_tvalid", 64'(m_axis_tvalid), 64'd1);
                check("stall_tdata", 64'(m_axis_tdata), 64'(prev_data));
                check("stall_tlast", 64'(m_axis_tlast), 64'(prev_last));
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 64'(m_axis_tdata), 64'hDEAD_0000_0000);
                end else begin
                    b = exp_q.pop_front();
                    check("beat_tdata", 64'(m_axis_tdata), 64'(b.d));
                    check("beat_tlast", 64'(m_axis_tlast), 64'(b.l));
                    nxt_pend = b.l;
                end
                beats++;
            end
            if (done || done_pend) check("done_pulse", 64'(done), 64'(done_pend));
            if (done) done_cnt++;
            if (busy) busy_cycles++;
            done_pend  = nxt_pend;
            prev_stall = m_axis_tvalid & ~m_axis_tready;
            prev_data  = m_axis_tdata;
            prev_last  = m_axis_tlast;
        end
    end

    function automatic logic [31:0] beat_word(input logic [31:0] d, input int i);
`ifdef AXIS_WORD_BURST_RAMP_EN
        return d + 32'(i);
`else
        return d + 32'(i * 0);
`endif
    endfunction

    task automatic wait_idle(input int budget);
        int c = 0;
        while ((busy || exp_q.size() != 0) && c < budget) begin
            @(posedge aclk);
            c++;
        end
        if (c >= budget) check("idle_timeout", 64'(c), 64'(budget - 1));
        @(posedge aclk);
        #1;
    endtask

    // Raise trigger with a fresh word; optionally scramble inputs during the burst
    task automatic start_burst(input logic [31:0] d, input logic [15:0] n, input bit scramble);
        beat_t b;
        trigger = 1'b0;
        @(posedge aclk);
        #1;
        data    = d;
        cfg_len = n;
        trigger = 1'b1;
        for (int i = 0; i < int'(n); i++) begin
            b.d = beat_word(d, i);
            b.l = (i == int'(n) - 1);
            exp_q.push_back(b);
        end
        if (n != 0) exp_bursts++;
        @(posedge aclk);
        #1;
        if (scramble) begin
            for (int j = 0; j < int'(n) - 1; j++) begin
                data    = $urandom;
                cfg_len = 16'($urandom_range(0, 40));
                trigger = 1'($urandom_range(0, 1));
                @(posedge aclk);
                #1;
            end
            trigger = 1'b1;
        end
    endtask

    initial begin
        int b0, d0, bc0;
        aresetn = 1'b0;
        data    = 32'h0;
        cfg_len = 16'h0;
        trigger = 1'b0;
        m_axis_tready = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_tlast", 64'(m_axis_tlast), 64'd0);
        check("rst_tdata", 64'(m_axis_tdata), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        aresetn  = 1'b1;
        in_reset = 1'b0;
        repeat (2) @(posedge aclk);
        #1;

        ready_mode  = 1;
        busy_cycles = 0;
        start_burst(32'hA5A5_A5A5, 16'd4, 1'b0);
        wait_idle(100);
        check("len4_busy_cycles", 64'(busy_cycles), 64'd5);

        ready_mode = 2;
        start_burst($urandom, 16'd3, 1'b1);
        wait_idle(100);

        ready_mode  = 1;
        b0 = beats; d0 = done_cnt; busy_cycles = 0;
        start_burst(32'h1234_5678, 16'd0, 1'b0);
        repeat (10) @(posedge aclk);
        #1;
        check("len0_beats", 64'(beats), 64'(b0));
        check("len0_done", 64'(done_cnt), 64'(d0));
        check("len0_busy", 64'(busy_cycles), 64'd0);

        start_burst(32'hCAFE_0001, 16'd8, 1'b1);
        wait_idle(100);
        start_burst(32'hFFFF_FFFE, 16'd3, 1'b0);
        wait_idle(100);
        start_burst($urandom, 16'd1, 1'b0);
        wait_idle(100);

        ready_mode = 0;
        for (int k = 0; k < 30; k++) begin
            start_burst($urandom, 16'($urandom_range(1, 20)), 1'($urandom_range(0, 1)));
            wait_idle(500);
        end

        // Reset two beats into a six-beat burst with trigger held high
        ready_mode = 1;
        b0 = beats;
        start_burst(32'h0BAD_F00D, 16'd6, 1'b0);
        begin
            int c = 0;
            while (beats < b0 + 2 && c < 50) begin
                @(negedge aclk);
                c++;
            end
            if (c >= 50) check("rst_wait_timeout", 64'(c), 64'd0);
        end
        #2;
        aresetn  = 1'b0;
        in_reset = 1'b1;
        #1;
        check("abort_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("abort_tlast", 64'(m_axis_tlast), 64'd0);
        check("abort_tdata", 64'(m_axis_tdata), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        exp_q.delete();
        exp_bursts--;
        repeat (2) @(posedge aclk);
        #2;
        aresetn  = 1'b1;
        in_reset = 1'b0;
        b0 = beats; bc0 = busy_cycles;
        repeat (8) @(posedge aclk);
        #1;
        check("post_rst_no_beats", 64'(beats), 64'(b0));
        check("post_rst_no_busy", 64'(busy_cycles), 64'(bc0));
        start_burst(32'h5555_AAAA, 16'd5, 1'b0);
        wait_idle(100);

        start_burst($urandom, 16'hFFFF, 1'b0);
        wait_idle(70000);

        repeat (3) @(posedge aclk);
        #1;
        check("done_count", 64'(done_cnt), 64'(exp_bursts));
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
